// File: rtl/assoc_cache_pkg.sv
// Shared types and helpers for the fully associative write-back cache.
package assoc_cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        RF_REQ,
        RF_WAIT,
        RESP
    } state_t;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BE_W       = WORD_W / 8;
    localparam int unsigned BYTE_OFF_W = 2;

    function automatic int unsigned tag_width(input int unsigned addr_w, input int unsigned words);
        return addr_w - BYTE_OFF_W - $clog2(words);
    endfunction

    function automatic logic [WORD_W-1:0] be_merge(input logic [WORD_W-1:0] old_w,
                                                  input logic [WORD_W-1:0] new_w,
                                                  input logic [BE_W-1:0]   be);
        logic [WORD_W-1:0] w_res;
        w_res = old_w;
        for (int unsigned b = 0; b < BE_W; b++) begin
            if (be[b]) w_res[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return w_res;
    endfunction

endpackage

// File: rtl/assoc_cache_match.sv
// Parallel tag compare over all lines plus lowest-index free-line search.
module assoc_cache_match #(
    parameter int unsigned LINES = 8,
    parameter int unsigned TAG_W = 27,
    parameter int unsigned IDX_W = $clog2(LINES)
) (
    input  logic [LINES-1:0]       i_valid,
    input  logic [LINES*TAG_W-1:0] i_tags,
    input  logic [TAG_W-1:0]       i_tag,
    output logic [LINES-1:0]       o_hit_vec,
    output logic [IDX_W-1:0]       o_hit_idx,
    output logic                   o_inv_found,
    output logic [IDX_W-1:0]       o_inv_idx
);

    always_comb begin
        o_hit_vec   = '0;
        o_hit_idx   = '0;
        o_inv_found = 1'b0;
        o_inv_idx   = '0;
        for (int unsigned i = 0; i < LINES; i++) begin
            o_hit_vec[i] = i_valid[i] && (i_tags[i*TAG_W +: TAG_W] == i_tag);
            if (o_hit_vec[i]) o_hit_idx = IDX_W'(i);
        end
        // Descending scan so the lowest free index is the one left standing.
        for (int unsigned i = LINES; i > 0; i--) begin
            if (!i_valid[i-1]) begin
                o_inv_found = 1'b1;
                o_inv_idx   = IDX_W'(i - 1);
            end
        end
    end

endmodule

// File: rtl/assoc_cache.sv
// Fully associative write-back/write-allocate cache with round-robin replacement.
// Optional hit/miss counters when ASSOC_CACHE_PERF_EN is defined.
module assoc_cache
    import assoc_cache_pkg::*;
#(
    parameter int unsigned LINES  = 8,
    parameter int unsigned WORDS  = 8,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [31:0]             req_wdata,
    input  logic [3:0]              req_be,
    output logic                    resp_valid,
    output logic [31:0]             resp_rdata,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_we,
    output logic [ADDR_W-1:0]       mem_req_addr,
    output logic [32*WORDS-1:0]     mem_wdata,
    input  logic                    mem_rvalid,
    input  logic [32*WORDS-1:0]     mem_rdata
`ifdef ASSOC_CACHE_PERF_EN
    ,
    output logic [31:0]             perf_hits,
    output logic [31:0]             perf_misses
`endif
);

    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned WOFF_W = $clog2(WORDS);
    localparam int unsigned TAG_W  = tag_width(ADDR_W, WORDS);

    typedef logic [WORDS-1:0][WORD_W-1:0] line_t;

    state_t                  r_state, w_next;
    logic [LINES-1:0]        r_valid, r_dirty;
    logic [TAG_W-1:0]        r_tag [LINES];
    line_t                   r_data [LINES];
    logic [IDX_W-1:0]        r_rr, r_victim;
    logic                    r_we;
    logic [TAG_W-1:0]        r_req_tag;
    logic [WOFF_W-1:0]       r_req_woff;
    logic [WORD_W-1:0]       r_wdata;
    logic [BE_W-1:0]         r_be;
    logic                    r_resp_valid;
    logic [WORD_W-1:0]       r_resp_rdata;

    logic [TAG_W-1:0]        w_req_tag;
    logic [WOFF_W-1:0]       w_req_woff;
    logic [LINES*TAG_W-1:0]  w_tags;
    logic [LINES-1:0]        w_hit_vec;
    logic [IDX_W-1:0]        w_hit_idx, w_inv_idx, w_victim;
    logic                    w_hit, w_inv_found, w_accept, w_fill;
    logic [WORD_W-1:0]       w_hit_word;
    line_t                   w_rdata_words, w_fill_line;

    assign w_req_tag     = req_addr[ADDR_W-1 -: TAG_W];
    assign w_req_woff    = req_addr[BYTE_OFF_W +: WOFF_W];
    assign w_rdata_words = mem_rdata;
    assign w_hit         = |w_hit_vec;
    assign w_accept      = (r_state == IDLE) && req_valid;
    assign w_fill        = (r_state == RF_WAIT) && mem_rvalid;
    assign w_victim      = w_inv_found ? w_inv_idx : r_rr;
    assign w_hit_word    = r_data[w_hit_idx][w_req_woff];

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign mem_wdata  = r_data[r_victim];

    always_comb begin
        w_tags = '0;
        for (int unsigned i = 0; i < LINES; i++) w_tags[i*TAG_W +: TAG_W] = r_tag[i];
    end

    assoc_cache_match #(
        .LINES (LINES),
        .TAG_W (TAG_W),
        .IDX_W (IDX_W)
    ) u_match (
        .i_valid     (r_valid),
        .i_tags      (w_tags),
        .i_tag       (w_req_tag),
        .o_hit_vec   (w_hit_vec),
        .o_hit_idx   (w_hit_idx),
        .o_inv_found (w_inv_found),
        .o_inv_idx   (w_inv_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        case (r_state)
            IDLE: begin
                if (w_accept && !w_hit)
                    w_next = (!w_inv_found && r_dirty[r_rr]) ? WB_REQ : RF_REQ;
            end
            WB_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {r_tag[r_victim], {(WOFF_W + BYTE_OFF_W){1'b0}}};
                if (mem_req_ready) w_next = RF_REQ;
            end
            RF_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {r_req_tag, {(WOFF_W + BYTE_OFF_W){1'b0}}};
                if (mem_req_ready) w_next = RF_WAIT;
            end
            RF_WAIT: if (mem_rvalid) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Refill line with any pending store already merged in.
    always_comb begin
        w_fill_line = w_rdata_words;
        if (r_we)
            w_fill_line[r_req_woff] = be_merge(w_rdata_words[r_req_woff], r_wdata, r_be);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid      <= '0;
            r_dirty      <= '0;
            r_rr         <= '0;
            r_victim     <= '0;
            r_we         <= 1'b0;
            r_req_tag    <= '0;
            r_req_woff   <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            for (int unsigned i = 0; i < LINES; i++) r_tag[i] <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            if (w_accept) begin
                if (w_hit) begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= req_we ? '0 : w_hit_word;
                    if (req_we) r_dirty[w_hit_idx] <= 1'b1;
                end else begin
                    r_we       <= req_we;
                    r_req_tag  <= w_req_tag;
                    r_req_woff <= w_req_woff;
                    r_wdata    <= req_wdata;
                    r_be       <= req_be;
                    r_victim   <= w_victim;
                    if (!w_inv_found) r_rr <= r_rr + IDX_W'(1);
                end
            end
            if (w_fill) begin
                r_valid[r_victim] <= 1'b1;
                r_dirty[r_victim] <= r_we;
                r_tag[r_victim]   <= r_req_tag;
                r_resp_valid      <= 1'b1;
                r_resp_rdata      <= r_we ? '0 : w_rdata_words[r_req_woff];
            end
        end
    end

    // Data array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_accept && w_hit && req_we)
            r_data[w_hit_idx][w_req_woff] <= be_merge(w_hit_word, req_wdata, req_be);
        if (w_fill)
            r_data[r_victim] <= w_fill_line;
    end

`ifdef ASSOC_CACHE_PERF_EN
    logic [31:0] r_perf_hits, r_perf_misses;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_hits   <= '0;
            r_perf_misses <= '0;
        end else if (w_accept) begin
            if (w_hit) begin
                if (r_perf_hits != '1) r_perf_hits <= r_perf_hits + 32'd1;
            end else begin
                if (r_perf_misses != '1) r_perf_misses <= r_perf_misses + 32'd1;
            end
        end
    end

    assign perf_hits   = r_perf_hits;
    assign perf_misses = r_perf_misses;
`endif

endmodule

// File: tb/tb_assoc_cache.sv
// Bench for assoc_cache: directed scenarios then random traffic against a line-level model.
module tb_assoc_cache;

    logic         clk, rst;
    logic         req_valid, req_ready, req_we;
    logic [31:0]  req_addr, req_wdata;
    logic [3:0]   req_be;
    logic         resp_valid;
    logic [31:0]  resp_rdata;
    logic         mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0]  mem_req_addr;
    logic [255:0] mem_wdata;
    logic         mem_rvalid;
    logic [255:0] mem_rdata;
`ifdef ASSOC_CACHE_PERF_EN
    logic [31:0]  perf_hits, perf_misses;
`endif

    assoc_cache #(.LINES(8), .WORDS(8), .ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_be        (req_be),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_wdata     (mem_wdata),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata)
`ifdef ASSOC_CACHE_PERF_EN
        ,
        .perf_hits     (perf_hits),
        .perf_misses   (perf_misses)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Model: cache contents, replacement pointer, backing memory, counters.
    bit           m_valid [8];
    bit           m_dirty [8];
    logic [26:0]  m_tag   [8];
    logic [255:0] m_data  [8];
    int unsigned  m_rr;
    int unsigned  m_hits, m_misses;
    logic [255:0] bmem [logic [26:0]];

    logic [31:0]  g_wb_addr, g_rf_addr, g_rdata;
    logic [255:0] g_wb_data;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] bline(input logic [26:0] t);
        logic [255:0] l;
        if (bmem.exists(t)) return bmem[t];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = {t[15:0], 16'(w)} ^ 32'h5A5A_0000;
        return l;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = be[b] ? n[b*8 +: 8] : o[b*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
        m_rr = 0;
        m_hits = 0;
        m_misses = 0;
    endtask

    // Plays the memory side of one line transfer, optionally stalling ready.
    task automatic serve(input bit we, input logic [31:0] addr, input logic [255:0] data, input int stall);
        for (int s = 0; s <= stall; s++) begin
            chk("mem_req_valid", mem_req_valid, 1'b1);
            chk("mem_req_we", mem_req_we, we);
            chk("mem_req_addr", mem_req_addr, addr);
            if (we) chk("mem_wdata", mem_wdata, data);
            chk("busy_req_ready", req_ready, 1'b0);
            chk("busy_resp_valid", resp_valid, 1'b0);
            if (we) begin
                g_wb_addr = mem_req_addr;
                g_wb_data = mem_wdata;
            end else begin
                g_rf_addr = mem_req_addr;
            end
            if (s == stall) begin
                mem_rvalid    = 1'b0;
                mem_req_ready = 1'b1;
            end else begin
                mem_rvalid = 1'($urandom_range(0, 1));
                mem_rdata  = {8{$urandom}};
            end
            @(negedge clk);
        end
        mem_req_ready = 1'b0;
        mem_rvalid    = 1'b0;
    endtask

    task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int stall, input bit abort);
        logic [26:0]  t;
        int           wo, hi, v;
        logic [31:0]  exp_r;
        logic [255:0] fill;
        t  = addr[31:5];
        wo = int'(addr[4:2]);
        hi = -1;
        g_wb_addr = '1;
        for (int i = 0; i < 8; i++) if (m_valid[i] && m_tag[i] == t) hi = i;

        chk("req_ready", req_ready, 1'b1);
        chk("resp_quiet", resp_valid, 1'b0);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_be = 4'($urandom);

        if (hi >= 0) begin
            m_hits++;
            if (we) begin
                m_data[hi][wo*32 +: 32] = merge(m_data[hi][wo*32 +: 32], wdata, be);
                m_dirty[hi] = 1;
                exp_r = '0;
            end else begin
                exp_r = m_data[hi][wo*32 +: 32];
            end
            chk("hit_resp_valid", resp_valid, 1'b1);
            chk("hit_resp_rdata", resp_rdata, exp_r);
            chk("hit_no_mem", mem_req_valid, 1'b0);
            g_rdata = resp_rdata;
            @(negedge clk);
            return;
        end

        m_misses++;
        v = -1;
        for (int i = 7; i >= 0; i--) if (!m_valid[i]) v = i;
        if (v < 0) begin
            v = int'(m_rr);
            m_rr = (m_rr + 1) % 8;
        end
        chk("miss_resp_quiet", resp_valid, 1'b0);
        if (m_valid[v] && m_dirty[v]) begin
            serve(1'b1, {m_tag[v], 5'd0}, m_data[v], stall);
            bmem[m_tag[v]] = m_data[v];
        end
        serve(1'b0, {t, 5'd0}, '0, stall);
        chk("rfwait_mem_idle", mem_req_valid, 1'b0);

        if (abort) begin
            rst = 1'b0;
            #1;
            chk("abort_resp_valid", resp_valid, 1'b0);
            chk("abort_mem_valid", mem_req_valid, 1'b0);
            chk("abort_req_ready", req_ready, 1'b1);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            chk("abort_no_resp", resp_valid, 1'b0);
            model_reset();
            return;
        end

        repeat ($urandom_range(0, 3)) begin
            chk("rfwait_no_resp", resp_valid, 1'b0);
            chk("rfwait_req_ready", req_ready, 1'b0);
            @(negedge clk);
        end
        fill = bline(t);
        mem_rvalid = 1'b1;
        mem_rdata  = fill;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = {8{$urandom}};

        m_valid[v] = 1;
        m_tag[v]   = t;
        m_data[v]  = fill;
        m_dirty[v] = we;
        if (we) m_data[v][wo*32 +: 32] = merge(fill[wo*32 +: 32], wdata, be);
        exp_r = we ? 32'h0 : m_data[v][wo*32 +: 32];
        chk("miss_resp_valid", resp_valid, 1'b1);
        chk("miss_resp_rdata", resp_rdata, exp_r);
        g_rdata = resp_rdata;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] l;
        logic [31:0]  a;
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        model_reset();
        #1;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_valid", mem_req_valid, 1'b0);
        chk("rst_mem_we", mem_req_we, 1'b0);
        chk("rst_mem_addr", mem_req_addr, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        l = bline(27'h8);
        l[31:0]  = 32'hDEADBEEF;
        l[63:32] = 32'h11223344;
        bmem[27'h8] = l;

        do_req(0, 32'h100, 0, 0, 0, 0);
        chk("cold_rf_addr", g_rf_addr, 32'h100);
        chk("cold_rdata", g_rdata, 32'hDEADBEEF);
        do_req(0, 32'h100, 0, 0, 0, 0);
        chk("warm_rdata", g_rdata, 32'hDEADBEEF);
        do_req(1, 32'h104, 32'h0000ABCD, 4'b0011, 0, 0);
        do_req(0, 32'h104, 0, 0, 0, 0);
        chk("merge_rdata", g_rdata, 32'h1122ABCD);

        do_req(1, 32'h1000, 32'hCAFEF00D, 4'hF, 0, 0);
        for (int k = 2; k < 8; k++) do_req(0, 32'(k) << 12, 0, 0, 1, 0);
        do_req(0, 32'h9000, 0, 0, 0, 0);
        chk("evict0_wb_addr", g_wb_addr, 32'h100);
        chk("evict0_wb_word1", g_wb_data[63:32], 32'h1122ABCD);
        chk("evict0_rf_addr", g_rf_addr, 32'h9000);
        do_req(0, 32'hA000, 0, 0, 5, 0);
        chk("evict1_wb_addr", g_wb_addr, 32'h1000);
        chk("evict1_wb_word0", g_wb_data[31:0], 32'hCAFEF00D);

        do_req(0, 32'hB000, 0, 0, 1, 1);
        do_req(0, 32'hB000, 0, 0, 0, 0);
        chk("post_abort_rf_addr", g_rf_addr, 32'hB000);
        do_req(0, 32'hB000, 0, 0, 0, 0);
        do_req(0, 32'hB004, 0, 0, 0, 0);
        do_req(1, 32'hB008, 32'h55, 4'h1, 0, 0);
        do_req(0, 32'hC000, 0, 0, 0, 0);
`ifdef ASSOC_CACHE_PERF_EN
        chk("perf_hits_lit", perf_hits, 32'd3);
        chk("perf_misses_lit", perf_misses, 32'd2);
`endif

        for (int n = 0; n < 300; n++) begin
            a = 32'h0004_0000 + (32'($urandom_range(0, 11)) << 5)
              + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
            do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), $urandom_range(0, 3), 0);
        end
`ifdef ASSOC_CACHE_PERF_EN
        chk("perf_hits", perf_hits, 32'(m_hits));
        chk("perf_misses", perf_misses, 32'(m_misses));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
